// File: rtl/serial_arith_pkg.sv
// ============================================================================
// serial_arith_pkg
// ----------------------------------------------------------------------------
// Purpose : Shared definitions for the bit-serial add/subtract sequencer.
//           Holds the sequencer state type and the default operand width so
//           the top level, the bit cell and any bench agree on them.
//
// Contents:
//   DEFAULT_WIDTH  default operand/result width in bits (legal 2..32)
//   state_t        sequencer states IDLE, SHIFT, DONE
// ============================================================================
package serial_arith_pkg;

    // Default operand and result width used by serial_adder_seq.
    localparam int DEFAULT_WIDTH = 8;

    // IDLE  : waiting for start, outputs hold the last result.
    // SHIFT : one operand bit pair is consumed per clock, LSB first.
    // DONE  : result valid, done pulses for this single cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : serial_arith_pkg

// File: rtl/fa_bit.sv
// ============================================================================
// fa_bit
// ----------------------------------------------------------------------------
// Purpose : Purely combinational one-bit full adder. This is the single
//           arithmetic cell that the serial sequencer time-multiplexes over
//           every bit position of the operands.
//
// Ports:
//   i_x   input  1  first operand bit
//   i_y   input  1  second operand bit (already inverted for subtract)
//   i_ci  input  1  carry in
//   o_s   output 1  sum bit
//   o_co  output 1  carry out
// ============================================================================
module fa_bit (
    input  logic i_x,
    input  logic i_y,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);

    logic w_xorXY;

    // Sum is the parity of the three inputs; carry is the majority.
    assign w_xorXY = i_x ^ i_y;
    assign o_s     = w_xorXY ^ i_ci;
    assign o_co    = (i_x & i_y) | (w_xorXY & i_ci);

endmodule : fa_bit

// File: rtl/serial_adder_seq.sv
// ============================================================================
// serial_adder_seq
// ----------------------------------------------------------------------------
// Purpose : Bit-serial add/subtract sequencer. Captures two WIDTH-bit
//           operands on an accepted start, then streams them LSB-first
//           through a single full-adder cell, one bit per clock. The carry
//           lives in a flip-flop between bits and each result bit is shifted
//           into the sum register from the top, so after WIDTH shifts the
//           LSB has arrived at bit 0. Area is traded for latency.
//
// Ports:
//   i_clk       input  1      rising-edge clock
//   i_rst       input  1      synchronous reset, active-high
//   i_start     input  1      request a new operation (only seen in IDLE)
//   i_sub       input  1      0 = a + b + cin, 1 = a - b
//   i_cin       input  1      carry-in for add, ignored for subtract
//   i_a         input  WIDTH  operand A, captured with start
//   i_b         input  WIDTH  operand B, captured with start
//   o_busy      output 1      high in SHIFT and DONE
//   o_done      output 1      one-cycle pulse, result valid
//   o_sum       output WIDTH  result, held until the next accepted start
//   o_cout      output 1      final carry out (subtract: 1 = no borrow)
//   o_overflow  output 1      signed overflow of the whole operation
//
// Timing: start accepted at edge E0, bits processed at E1..E_WIDTH, done is
// high in the cycle following E_WIDTH, back to IDLE on the next edge.
// ============================================================================
module serial_adder_seq
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_sub,
    input  logic             i_cin,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_overflow
);

    // Bit counter only has to reach WIDTH-1.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    state_t             r_state;
    state_t             w_nextState;

    logic [WIDTH-1:0]   r_aSh;
    logic [WIDTH-1:0]   r_bSh;
    logic [WIDTH-1:0]   r_sum;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic               r_cout;
    logic               r_overflow;

    logic               w_load;
    logic               w_shift;
    logic               w_lastBit;
    logic               w_s;
    logic               w_co;
    logic               w_busy;
    logic               w_done;

    // ------------------------------------------------------------------------
    // Qualifiers derived from the current state. A start is only honoured
    // in IDLE; anything arriving while busy is simply dropped, never queued.
    // ------------------------------------------------------------------------
    assign w_load    = (r_state == IDLE) && i_start;
    assign w_shift   = (r_state == SHIFT);
    assign w_lastBit = w_shift && (r_cnt == LAST_CNT);

    // ------------------------------------------------------------------------
    // The single arithmetic cell, fed by the low bits of the operand shift
    // registers and the registered carry.
    // ------------------------------------------------------------------------
    fa_bit u_faBit (
        .i_x  (r_aSh[0]),
        .i_y  (r_bSh[0]),
        .i_ci (r_carry),
        .o_s  (w_s),
        .o_co (w_co)
    );

    // ------------------------------------------------------------------------
    // State register. Reset is synchronous so a reset mid-operation lands
    // on a clock edge and the sequencer returns straight to IDLE without
    // passing through DONE.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and handshake outputs. DONE always lasts exactly one cycle,
    // which is what gives back-to-back starts a single IDLE cycle between
    // operations.
    // ------------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_nextState = SHIFT;
                end
            end
            SHIFT: begin
                w_busy = 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath. On load, subtract is set up as a + ~b + 1 by inverting B and
    // preloading the carry with 1. Each shift step pushes the new sum bit in
    // at the MSB end so the result ends up in natural bit order. The result
    // registers are not touched on load, so the previous result stays
    // visible until the first bit of the new operation is written.
    // On the MSB step the carry still holds the carry into the MSB, so its
    // XOR with the cell carry out is the signed overflow. The counter is
    // returned to zero there so it never goes past WIDTH-1.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_aSh      <= '0;
            r_bSh      <= '0;
            r_sum      <= '0;
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_load) begin
            r_aSh   <= i_a;
            r_bSh   <= i_sub ? ~i_b : i_b;
            r_carry <= i_sub ? 1'b1 : i_cin;
            r_cnt   <= '0;
        end else if (w_shift) begin
            r_sum   <= {w_s, r_sum[WIDTH-1:1]};
            r_aSh   <= {1'b0, r_aSh[WIDTH-1:1]};
            r_bSh   <= {1'b0, r_bSh[WIDTH-1:1]};
            r_carry <= w_co;
            if (w_lastBit) begin
                r_cnt      <= '0;
                r_cout     <= w_co;
                r_overflow <= r_carry ^ w_co;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output drive.
    // ------------------------------------------------------------------------
    assign o_busy     = w_busy;
    assign o_done     = w_done;
    assign o_sum      = r_sum;
    assign o_cout     = r_cout;
    assign o_overflow = r_overflow;

endmodule : serial_adder_seq

// File: tb/tb_serial_adder_seq.sv
// ============================================================================
// tb_serial_adder_seq
// ----------------------------------------------------------------------------
// Self-checking bench for serial_adder_seq at WIDTH = 8. Directed vectors
// from a table, hand-written multi-cycle sequences (ignored starts, reset
// mid-operation, held start) and random operations checked against an
// integer arithmetic reference model.
// ============================================================================
module tb_serial_adder_seq;
    import serial_arith_pkg::*;

    localparam int W = 8;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_start = 1'b0;
    logic         i_sub = 1'b0;
    logic         i_cin = 1'b0;
    logic [W-1:0] i_a = '0;
    logic [W-1:0] i_b = '0;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_sum;
    logic         o_cout;
    logic         o_overflow;

    int nCompared   = 0;
    int nMismatched = 0;

    serial_adder_seq #(.WIDTH(W)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_sub      (i_sub),
        .i_cin      (i_cin),
        .i_a        (i_a),
        .i_b        (i_b),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_sum      (o_sum),
        .o_cout     (o_cout),
        .o_overflow (o_overflow)
    );

    // Free-running clock, 10 time units per period.
    always #5 i_clk = ~i_clk;

    // Hard stop in case something stalls outside the bounded loops.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
        logic [W-1:0] expSum;
        logic         expCout;
        logic         expOv;
    } vec_t;

    // Compare one value and count it.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive the request inputs.
    task automatic applyStimulus(input logic start, input logic sub, input logic cin,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
        i_start = start;
        i_sub   = sub;
        i_cin   = cin;
        i_a     = a;
        i_b     = b;
    endtask

    // Reference: plain integer arithmetic. Unsigned total gives sum/cout,
    // signed result outside the W-bit range gives overflow.
    task automatic refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sub, input logic cin,
                            output logic [W-1:0] rSum, output logic rCout,
                            output logic rOv);
        int ua, ub, full, sa, sb, sres;
        logic [W-1:0] nb;
        nb   = ~b;
        ua   = int'(a);
        ub   = sub ? int'(nb) : int'(b);
        full = ua + ub + (sub ? 1 : int'(cin));
        rSum  = full[W-1:0];
        rCout = full[W];
        sa   = $signed(a);
        sb   = $signed(b);
        sres = sub ? (sa - sb) : (sa + sb + int'(cin));
        rOv  = (sres > (2 ** (W - 1)) - 1) || (sres < -(2 ** (W - 1)));
    endtask

    // One full operation: start for one edge, scramble the inputs while
    // busy, then watch until the sequencer is idle again.
    task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic cin,
                         output logic [W-1:0] gotSum, output logic gotCout,
                         output logic gotOv, output int doneEdge,
                         output int doneCount, output int busyCount);
        applyStimulus(1'b1, sub, cin, a, b);
        @(posedge i_clk);
        #1;
        applyStimulus(1'b0, 1'($urandom), 1'($urandom), W'($urandom), W'($urandom));
        busyCount = o_busy ? 1 : 0;
        doneCount = 0;
        doneEdge  = -1;
        gotSum    = o_sum;
        gotCout   = o_cout;
        gotOv     = o_overflow;
        for (int k = 1; k <= 3 * W; k++) begin
            @(posedge i_clk);
            #1;
            if (o_busy) busyCount++;
            if (o_done) begin
                doneCount++;
                if (doneEdge < 0) doneEdge = k;
                gotSum  = o_sum;
                gotCout = o_cout;
                gotOv   = o_overflow;
            end
            if (!o_busy) break;
        end
    endtask

    vec_t vecs[8];

    initial begin
        logic [W-1:0] gSum, eSum;
        logic         gCout, gOv, eCout, eOv;
        int           dEdge, dCount, bCount;
        int           firstDone, secondDone;

        vecs[0] = '{8'h3C, 8'h25, 1'b0, 1'b0, 8'h61, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h80, 8'h80, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1};

        // ---------------- reset state ----------------
        repeat (3) @(posedge i_clk);
        #1;
        checkOutput("reset busy", 32'(o_busy), 32'd0);
        checkOutput("reset done", 32'(o_done), 32'd0);
        checkOutput("reset sum", 32'(o_sum), 32'd0);
        checkOutput("reset cout", 32'(o_cout), 32'd0);
        checkOutput("reset overflow", 32'(o_overflow), 32'd0);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        // ---------------- directed table ----------------
        for (int i = 0; i < 8; i++) begin
            runOp(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin,
                  gSum, gCout, gOv, dEdge, dCount, bCount);
            checkOutput($sformatf("vec%0d sum", i), 32'(gSum), 32'(vecs[i].expSum));
            checkOutput($sformatf("vec%0d cout", i), 32'(gCout), 32'(vecs[i].expCout));
            checkOutput($sformatf("vec%0d overflow", i), 32'(gOv), 32'(vecs[i].expOv));
            checkOutput($sformatf("vec%0d done edge", i), 32'(dEdge), 32'(W));
            checkOutput($sformatf("vec%0d done count", i), 32'(dCount), 32'd1);
            checkOutput($sformatf("vec%0d busy cycles", i), 32'(bCount), 32'(W + 1));
            checkOutput($sformatf("vec%0d sum hold", i), 32'(o_sum), 32'(vecs[i].expSum));
        end

        // ---------------- starts while busy are ignored ----------------
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h3C, 8'h25);
        @(posedge i_clk);
        #1;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        dCount = 0;
        dEdge  = -1;
        gSum   = '0;
        for (int k = 1; k <= 14; k++) begin
            if (k == 3 || k == 9) applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
            else                  applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            @(posedge i_clk);
            #1;
            if (o_done) begin
                dCount++;
                if (dEdge < 0) dEdge = k;
                gSum = o_sum;
            end
            if (k == 3)  checkOutput("ignore busy after E3", 32'(o_busy), 32'd1);
            if (k == 9)  checkOutput("ignore busy after E9", 32'(o_busy), 32'd0);
            if (k == 10) checkOutput("ignore busy after E10", 32'(o_busy), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("ignore done count", 32'(dCount), 32'd1);
        checkOutput("ignore done edge", 32'(dEdge), 32'(W));
        checkOutput("ignore sum", 32'(gSum), 32'h61);
        checkOutput("ignore sum hold", 32'(o_sum), 32'h61);

        // ---------------- reset mid-operation ----------------
        runOp(8'h80, 8'h01, 1'b1, 1'b0, gSum, gCout, gOv, dEdge, dCount, bCount);
        checkOutput("pre-reset cout", 32'(gCout), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hAA, 8'h55);
        @(posedge i_clk);
        #1;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        checkOutput("midrst busy", 32'(o_busy), 32'd0);
        checkOutput("midrst done", 32'(o_done), 32'd0);
        checkOutput("midrst sum", 32'(o_sum), 32'd0);
        checkOutput("midrst cout", 32'(o_cout), 32'd0);
        checkOutput("midrst overflow", 32'(o_overflow), 32'd0);
        dCount = 0;
        bCount = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge i_clk);
            #1;
            if (o_done) dCount++;
            if (o_busy) bCount++;
        end
        checkOutput("midrst no done", 32'(dCount), 32'd0);
        checkOutput("midrst stays idle", 32'(bCount), 32'd0);
        runOp(8'h10, 8'h20, 1'b0, 1'b0, gSum, gCout, gOv, dEdge, dCount, bCount);
        checkOutput("postrst sum", 32'(gSum), 32'h30);
        checkOutput("postrst done edge", 32'(dEdge), 32'(W));

        // ---------------- start held high: back-to-back ----------------
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h12, 8'h34);
        firstDone  = -1;
        secondDone = -1;
        gSum       = '0;
        for (int k = 1; k <= 4 * W; k++) begin
            @(posedge i_clk);
            #1;
            if (o_done) begin
                if (firstDone < 0) firstDone = k;
                else if (secondDone < 0) secondDone = k;
                gSum = o_sum;
            end
            if (secondDone >= 0) break;
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("b2b first done", 32'(firstDone), 32'(W + 1));
        checkOutput("b2b spacing", 32'(secondDone - firstDone), 32'(W + 2));
        checkOutput("b2b sum", 32'(gSum), 32'h46);
        for (int k = 0; k < 3 * W; k++) begin
            @(posedge i_clk);
            #1;
            if (!o_busy) break;
        end
        checkOutput("b2b back to idle", 32'(o_busy), 32'd0);

        // ---------------- random operations vs reference ----------------
        for (int n = 0; n < 60; n++) begin
            logic [W-1:0] ra, rb;
            logic         rs, rc;
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            rc = 1'($urandom);
            if (n % 10 == 0) ra = '1;
            if (n % 10 == 1) rb = '1;
            refModel(ra, rb, rs, rc, eSum, eCout, eOv);
            runOp(ra, rb, rs, rc, gSum, gCout, gOv, dEdge, dCount, bCount);
            checkOutput($sformatf("rand%0d sum", n), 32'(gSum), 32'(eSum));
            checkOutput($sformatf("rand%0d cout", n), 32'(gCout), 32'(eCout));
            checkOutput($sformatf("rand%0d overflow", n), 32'(gOv), 32'(eOv));
            checkOutput($sformatf("rand%0d done edge", n), 32'(dEdge), 32'(W));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge i_clk);
                #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule : tb_serial_adder_seq

// File: doc/serial_adder_seq.md
Name: serial_adder_seq

Overview:
- Bit-serial add/subtract sequencer: the control and data stage that feeds a one-bit full-adder cell.
- Loads two WIDTH-bit operands and streams them LSB-first through the cell, one bit per clock.
- Holds the carry in a flip-flop between bits and shifts result bits into a sum register.
- Start/busy/done handshake; used where area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request a new operation; sampled only in IDLE
- sub  input  1  0 = add, 1 = subtract (a - b); sampled with start
- cin  input  1  carry-in for add; ignored when sub = 1
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while an operation is in progress (states SHIFT and DONE)
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  result; holds until the next accepted start
- cout  output  1  final carry out; for subtract, 1 = no borrow
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- One clock (clk); synchronous active-high reset (rst); no asynchronous logic.
- Reset values:
  - state = IDLE
  - busy, done, cout, overflow = 0
  - sum = 0
  - operand shift registers, carry flip-flop and bit counter = 0
- States: IDLE, SHIFT, DONE.
- IDLE, start = 1 at edge E0:
  - load a_sh <= a.
  - load b_sh <= sub ? ~b : b.
  - carry <= sub ? 1 : cin.
  - cnt <= 0; state -> SHIFT.
  - sum, cout and overflow keep their previous values until E1.
- SHIFT, each edge E1..E_WIDTH:
  - bit cell computes s, co from a_sh[0], b_sh[0], carry.
  - sum <= {s, sum[WIDTH-1:1]}.
  - a_sh and b_sh shift right by one, zero-filled.
  - carry <= co; cnt <= cnt + 1.
  - On the edge where cnt == WIDTH-1 (the MSB bit):
    - cout <= co.
    - overflow <= carry XOR co, using the carry value before update.
    - state -> DONE.
- DONE:
  - done = 1 for exactly one cycle; state -> IDLE at the next edge.
- Latency and outputs:
  - done is high in the cycle after edge E_WIDTH, i.e. WIDTH+1 edges after the start edge.
  - sum, cout and overflow are stable from E_WIDTH onward.
  - busy = 1 in SHIFT and DONE; 0 in IDLE.
- start handling:
  - start in SHIFT or DONE is ignored; it is not queued.
  - start held high continuously gives back-to-back operations with one IDLE cycle between them.
- Arithmetic: sum is modulo 2^WIDTH.
  - Subtract is a + ~b + 1.
  - cout = 0 on subtract means a < b (unsigned).
- Counter width is $clog2(WIDTH); cnt never exceeds WIDTH-1.
- rst mid-operation:
  - takes effect at that edge.
  - all state returns to reset values; no done pulse is produced.
- Operands changing while busy have no effect; only the registered copies are used.

Decomposition:
- Shared package serial_arith_pkg holds:
  - state enum (IDLE, SHIFT, DONE).
  - default width constant (8).
- One sub-module, fa_bit: purely combinational one-bit full adder (s, co from x, y, ci), instantiated once.
- Sequencing, shift registers and flags stay in serial_adder_seq.

Test Plan:
- Add, WIDTH=8: a=0x3C, b=0x25, cin=0, sub=0 -> done pulses 9 edges after start; sum=0x61, cout=0, overflow=0; busy high for 9 cycles.
- Unsigned wrap: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0. Same operands with cin=1 -> sum=0x01, cout=1.
- Signed overflow: a=0x7F, b=0x01 -> sum=0x80, cout=0, overflow=1.
- Subtract: a=0x05, b=0x07, sub=1, cin=1 (ignored) -> sum=0xFE, cout=0, overflow=0. Then a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, overflow=1.
- start pulsed again at edges E3 and E9 of an operation (during SHIFT and during DONE), with new operands -> ignored; first result unchanged; exactly one done pulse; busy low at edge E10.
- rst asserted at edge E4 of an operation -> at that edge busy=0, sum=0, cout=0, overflow=0; no done pulse. A new start afterwards (0x10+0x20) -> sum=0x30 with normal 9-edge latency.
